regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the three-ported register file. Two result producers compete for the register file's single write port:
- A: ALU/execute result.
- B: load/multi-cycle unit result.

The block arbitrates them round-robin and drives the write port from a registered stage. It also keeps a per-register pending-write scoreboard that the issue logic uses for RAW/WAW stall decisions.

---
 rtl/regfile_wb_scheduler_pkg.sv | 21 ++
 rtl/regfile_wb_scheduler_rr_arbiter2.sv | 39 +++
 rtl/regfile_wb_scheduler.sv | 123 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Widths match the register file (32 x 32-bit, 5-bit index) and the
// scoreboard counter width; grant encodings are used by rr_arbiter2.
package regfile_wb_scheduler_pkg;

  localparam int WORD_LEN      = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int REG_COUNT     = 32;
  localparam int PEND_W        = 2;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // A pending counter at all-ones cannot take another outstanding write.
  function automatic logic pend_full(input logic [PEND_W-1:0] cnt);
    return &cnt;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; owns the last_grant flop.
// Latency: grants are combinational from req_* and last_grant (0 cycles).
// Backpressure: the losing requester sees no grant and must hold its request.
// Ports: clk, rst (async, active-high), req_a/req_b in, gnt_a/gnt_b out.
module rr_arbiter2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  grant_e last_grant_q;
  grant_e last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Starting at B means A wins the first tie.
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    gnt_a        = req_a && (!req_b || (last_grant_q == GRANT_B));
    gnt_b        = req_b && !gnt_a;
    last_grant_d = last_grant_q;
    if (gnt_a) begin
      last_grant_d = GRANT_A;
    end else if (gnt_b) begin
      last_grant_d = GRANT_B;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates ALU (A) and load/multi-cycle (B) results
// onto the single register-file write port and tracks pending writes.
// Latency: accepted result appears on writeEnable/Addr/Data one cycle later.
// Backpressure: a_ready/b_ready low for the loser; iss_ready low when the
//   destination's pending counter is full.
// Ports: clk, rst; issue scoreboard (iss_valid/iss_rd/iss_ready, rs1/rs2,
//   busy1/busy2); producers a_*/b_* (valid/rd/data/ready); write port
//   writeEnable/writeAddr/writeData.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic [REG_IDX_WIDTH-1:0] iss_rd,
  output logic                     iss_ready,
  input  logic [REG_IDX_WIDTH-1:0] rs1,
  input  logic [REG_IDX_WIDTH-1:0] rs2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     a_valid,
  input  logic [REG_IDX_WIDTH-1:0] a_rd,
  input  logic [WORD_LEN-1:0]      a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [REG_IDX_WIDTH-1:0] b_rd,
  input  logic [WORD_LEN-1:0]      b_data,
  output logic                     b_ready,
  output logic                     writeEnable,
  output logic [REG_IDX_WIDTH-1:0] writeAddr,
  output logic [WORD_LEN-1:0]      writeData
);

  logic                     gnt_a;
  logic                     gnt_b;
  logic                     grant_vld;
  logic [REG_IDX_WIDTH-1:0] grant_rd;
  logic [WORD_LEN-1:0]      grant_dat;
  logic                     iss_fire;

  logic                     write_en_q, write_en_d;
  logic [REG_IDX_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [WORD_LEN-1:0]      write_data_q, write_data_d;

  logic [PEND_W-1:0]        cnt_q [REG_COUNT];
  logic [PEND_W-1:0]        cnt_d [REG_COUNT];

  // Requests are masked during reset so nothing is accepted (and then lost)
  // while the write stage is being cleared.
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (a_valid && !rst),
    .req_b (b_valid && !rst),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_comb begin
    a_ready   = gnt_a;
    b_ready   = gnt_b;
    grant_vld = gnt_a || gnt_b;
    grant_rd  = gnt_a ? a_rd   : b_rd;
    grant_dat = gnt_a ? a_data : b_data;
  end

  // Write stage: address/data hold when idle; x0 writes are suppressed.
  always_comb begin
    write_en_d   = grant_vld && (grant_rd != '0);
    write_addr_d = grant_vld ? grant_rd  : write_addr_q;
    write_data_d = grant_vld ? grant_dat : write_data_q;
  end

  always_comb begin
    iss_ready = (iss_rd == '0) || !pend_full(cnt_q[iss_rd]);
    iss_fire  = iss_valid && iss_ready;
    busy1     = (rs1 != '0) && (cnt_q[rs1] != '0);
    busy2     = (rs2 != '0) && (cnt_q[rs2] != '0);
  end

  // Scoreboard next state. x0 has no counter. A simultaneous issue and grant
  // to the same register cancel. A grant on an empty counter is a protocol
  // error and is clamped at zero instead of wrapping.
  always_comb begin
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (iss_fire && (iss_rd == REG_IDX_WIDTH'(r)) &&
          !(grant_vld && (grant_rd == REG_IDX_WIDTH'(r)))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (grant_vld && (grant_rd == REG_IDX_WIDTH'(r)) &&
                   !(iss_fire && (iss_rd == REG_IDX_WIDTH'(r))) &&
                   (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    writeEnable = write_en_q;
    writeAddr   = write_addr_q;
    writeData   = write_data_q;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1, rs2;
  logic        busy1, busy2;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy1       (busy1),
    .busy2       (busy2),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests  = 0;
  int  failed = 0;

  // Reference model: number of outstanding writes per register, and which
  // producer won last (1 = B), so A wins the first tie.
  int  pend_m [32];
  bit  last_b_m;
  bit  a_acc, b_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-port pulse must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && writeEnable) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL wr_unexpected: got addr %0d data %0h, expected no write", writeAddr, writeData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", writeAddr, e.addr);
        chk("wr_data", writeData, e.data);
      end
    end
  end

  // One clock cycle: check combinational outputs against the model at the
  // falling edge, advance the model, and return 1 time unit after posedge.
  task automatic step();
    bit ga, gb, rdy, iss_ok;
    logic [4:0]  grd;
    logic [31:0] gdat;
    @(negedge clk);
    ga     = a_valid && (!b_valid || last_b_m);
    gb     = b_valid && !ga;
    rdy    = (iss_rd == 0) || (pend_m[iss_rd] < 3);
    iss_ok = iss_valid && rdy;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("iss_ready", iss_ready, rdy);
    chk("busy1", busy1, (rs1 != 0) && (pend_m[rs1] != 0));
    chk("busy2", busy2, (rs2 != 0) && (pend_m[rs2] != 0));
    if (iss_ok && iss_rd != 0) pend_m[iss_rd]++;
    if (ga || gb) begin
      grd  = ga ? a_rd : b_rd;
      gdat = ga ? a_data : b_data;
      last_b_m = gb;
      if (grd != 0) begin
        if (pend_m[grd] > 0) pend_m[grd]--;
        exp_q.push_back('{addr: grd, data: gdat});
      end
    end
    a_acc = ga;
    b_acc = gb;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend_m[r] = 0;
    last_b_m = 1'b1;
    exp_q.delete();
    a_acc = 1'b0;
    b_acc = 1'b0;
  endtask

  // Assert reset mid-cycle with producers still valid; outputs and the
  // scoreboard must clear without waiting for a clock edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_we", writeEnable, 0);
    chk("rst_addr", writeAddr, 0);
    chk("rst_data", writeData, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    for (int r = 0; r < 32; r++) begin
      rs1 = r[4:0];
      rs2 = 5'(31 - r);
      #0.1;
      chk("rst_busy1", busy1, 0);
      chk("rst_busy2", busy2, 0);
    end
    model_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    iss_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_we", writeEnable, 0);
    chk("reset_addr", writeAddr, 0);
    chk("reset_data", writeData, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Contention: both producers held for 4 cycles -> A, B, A, B.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rd = 5'd1;
      b_valid = 1; b_rd = 5'd2;
      if (i == 0 || a_acc) a_data = $urandom;
      if (i == 0 || b_acc) b_data = $urandom;
      step();
      chk("contention_a", a_acc, (i % 2) == 0);
      chk("contention_b", b_acc, (i % 2) == 1);
    end
    a_valid = 0; b_valid = 0;

    // Single write to r5 with busy tracking.
    iss_valid = 1; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    step();
    iss_valid = 0;
    a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 0;
    chk("single_we", writeEnable, 1);
    chk("single_addr", writeAddr, 5);
    chk("single_data", writeData, 32'hDEADBEEF);
    chk("single_busy1", busy1, 0);
    step();
    chk("single_idle_we", writeEnable, 0);
    chk("single_hold_data", writeData, 32'hDEADBEEF);

    // x0: issue is always ready, write to x0 never enables the port.
    iss_valid = 1; iss_rd = 5'd0;
    step();
    iss_valid = 0;
    a_valid = 1; a_rd = 5'd0; a_data = 32'h12345678;
    step();
    a_valid = 0;
    chk("x0_we", writeEnable, 0);
    chk("x0_addr", writeAddr, 0);

    // WAW on r7: fill, cancel issue+grant, saturate, drain one.
    rs1 = 5'd7;
    iss_valid = 1; iss_rd = 5'd7;
    step();
    step();
    a_valid = 1; a_rd = 5'd7; a_data = 32'hA7A7A7A7;
    step();
    a_valid = 0;
    step();
    chk("waw_full", iss_ready, 0);
    step();
    iss_valid = 0;
    b_valid = 1; b_rd = 5'd7; b_data = 32'hB7B7B7B7;
    step();
    b_valid = 0;
    chk("waw_ready_after_drain", iss_ready, 1);
    chk("waw_busy", busy1, 1);

    // Hold stability: B loses to A, then goes through with unchanged data.
    a_valid = 1; a_rd = 5'd4; a_data = 32'h44444444;
    b_valid = 1; b_rd = 5'd6; b_data = 32'h66666666;
    step();
    chk("hold_a_first", a_acc, 1);
    chk("hold_b_wait", b_acc, 0);
    a_valid = 0;
    step();
    chk("hold_b_next", b_acc, 1);
    b_valid = 0;
    step();

    // Randomized traffic with a mid-run reset.
    a_acc = 0; b_acc = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) mid_reset();
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd    = 5'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd    = 5'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 9));
      rs2       = 5'($urandom_range(0, 9));
      step();
    end

    a_valid = 0; b_valid = 0; iss_valid = 0;
    step();
    step();
    chk("writes_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
